// File: rtl/match_ctrl.sv
// match_ctrl: match sequencer for the Pong core.
// Owns both scores, the serve delay, pause and win detection. All outputs
// are registered. The current FSM state is exported on 'state' for debug.
//
// Pulse semantics: start, pause and game_tick are one-cycle pulses sampled
// at each rising clk edge. point_p1/point_p2 are levels, and only their
// rising edges count. round_rst is a one-cycle output pulse. There is no
// valid/ready back-pressure: every input pulse is either acted on in the
// cycle it is seen or dropped.
module match_ctrl #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 120,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               game_tick,
  input  logic               start,
  input  logic               pause,
  input  logic               point_p1,
  input  logic               point_p2,
  output logic               round_rst,
  output logic               ball_en,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_SERVE  = 3'b001;
  localparam logic [2:0] S_PLAY   = 3'b010;
  localparam logic [2:0] S_PAUSED = 3'b011;
  localparam logic [2:0] S_OVER   = 3'b100;

  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LD = CNT_W'(SERVE_TICKS);

  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               p1_q, p2_q;
  logic               edge_p1, edge_p2;
  logic [2:0]         state_n;
  logic [SCORE_W-1:0] score_1_n, score_2_n;
  logic [SCORE_W-1:0] inc_1, inc_2;
  logic [1:0]         winner_n;
  logic               round_rst_n;

  // Rising edges of the point levels; the registers track in every state.
  assign edge_p1 = point_p1 & ~p1_q;
  assign edge_p2 = point_p2 & ~p2_q;
  assign inc_1   = score_1 + SCORE_W'(1);
  assign inc_2   = score_2 + SCORE_W'(1);

  // Next-state, score, winner, counter and round-reset decision.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    score_1_n   = score_1;
    score_2_n   = score_2;
    winner_n    = winner;
    round_rst_n = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        // A new match starts from cleared scores with a fresh serve.
        if (start) begin
          score_1_n   = '0;
          score_2_n   = '0;
          winner_n    = 2'b00;
          round_rst_n = 1'b1;
          cnt_n       = SERVE_LD;
          state_n     = S_SERVE;
        end
      end
      S_SERVE: begin
        // Only game ticks advance the serve delay.
        if (game_tick) begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        if (edge_p1 && edge_p2) begin
          // Simultaneous points: replay the round without scoring.
          round_rst_n = 1'b1;
          cnt_n       = SERVE_LD;
          state_n     = S_SERVE;
        end else if (edge_p1) begin
          score_1_n = inc_1;
          if (inc_1 == WIN_VAL) begin
            winner_n = 2'b01;
            state_n  = S_OVER;
          end else begin
            round_rst_n = 1'b1;
            cnt_n       = SERVE_LD;
            state_n     = S_SERVE;
          end
        end else if (edge_p2) begin
          score_2_n = inc_2;
          if (inc_2 == WIN_VAL) begin
            winner_n = 2'b10;
            state_n  = S_OVER;
          end else begin
            round_rst_n = 1'b1;
            cnt_n       = SERVE_LD;
            state_n     = S_SERVE;
          end
        end else if (pause) begin
          // A point in the same cycle wins over pause (handled above).
          state_n = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause) begin
          state_n = S_PLAY;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      cnt       <= '0;
      score_1   <= '0;
      score_2   <= '0;
      winner    <= 2'b00;
      round_rst <= 1'b0;
      ball_en   <= 1'b0;
      // Preset high so a level held through reset never looks like an edge.
      p1_q      <= 1'b1;
      p2_q      <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      score_1   <= score_1_n;
      score_2   <= score_2_n;
      winner    <= winner_n;
      round_rst <= round_rst_n;
      ball_en   <= (state_n == S_PLAY);
      p1_q      <= point_p1;
      p2_q      <= point_p2;
    end
  end

endmodule
